// File: rtl/vx_gpr_operand_fetch_pkg.sv
// Shared definitions for the GPR operand-fetch slice.
//   - fetch_state_t : operand-fetch FSM state (IDLE, READ3)
//   - gpr_addr()    : builds the GPR RAM address {wid, rid}
package vx_gpr_operand_fetch_pkg;

    typedef logic [0:0] fetch_state_t;

    localparam fetch_state_t FETCH_IDLE  = 1'b0;
    localparam fetch_state_t FETCH_READ3 = 1'b1;

    // Returns {wid, rid} right-aligned in 32 bits; callers truncate to the RAM address width.
    function automatic logic [31:0] gpr_addr(input logic [31:0]  wid,
                                             input logic [31:0]  rid,
                                             input int unsigned  ridw);
        return (wid << ridw) | rid;
    endfunction

endpackage

// File: rtl/vx_gpr_bypass.sv
// Read-port forwarding for the GPR RAM.
// The RAM returns old data when read and written at the same address in the same cycle, so the
// in-flight writeback data is forwarded here. Register 0 is forced to zero when ZERO_R0 is set,
// which takes priority over forwarding.
// Ports:
//   raddr    in   ADDRW  read address presented to the RAM ({wid, rid})
//   rdata    in   DATAW  RAM read data
//   wren     in   1      RAM write enable this cycle
//   waddr    in   ADDRW  RAM write address
//   wdata    in   DATAW  RAM write data
//   fwd_data out  DATAW  operand value after forwarding and r0 forcing
module vx_gpr_bypass
    import vx_gpr_operand_fetch_pkg::*;
#(
    parameter int unsigned ADDRW   = 7,
    parameter int unsigned DATAW   = 128,
    parameter int unsigned RIDW    = 5,
    parameter int unsigned ZERO_R0 = 1
) (
    input  logic [ADDRW-1:0] raddr,
    input  logic [DATAW-1:0] rdata,
    input  logic             wren,
    input  logic [ADDRW-1:0] waddr,
    input  logic [DATAW-1:0] wdata,
    output logic [DATAW-1:0] fwd_data
);

    always_comb begin
        fwd_data = rdata;
        if (wren && (waddr == raddr)) begin
            fwd_data = wdata;
        end
        if ((ZERO_R0 != 0) && (raddr[RIDW-1:0] == '0)) begin
            fwd_data = '0;
        end
    end

endmodule

// File: rtl/vx_gpr_operand_fetch.sv
// Read-side controller for the per-core GPR RAM (1 write port, 2 async read ports).
// Accepts issue requests with 2 or 3 source registers; rs1/rs2 are read in the accept cycle,
// rs3 in a second cycle on read port 1. Operands return through a 1-entry valid/ready register.
// The RAM write port is driven straight from writeback, which is never back-pressured.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req_valid/ready               issue handshake
//   req_wid, req_rs1/2/3          warp id and source register ids
//   req_use_rs3, req_tag          three-operand flag, passthrough tag
//   wb_valid, wb_wid, wb_rd, wb_data   writeback
//   ram_wren, ram_waddr, ram_wdata     RAM write port
//   ram_raddr1/2, ram_rdata1/2         RAM read ports (data valid in the same cycle)
//   rsp_valid/ready               response handshake
//   rsp_wid, rsp_tag              echoed from the request
//   rsp_rs1/2/3_data              operands (rs3 = 0 for two-operand requests)
module vx_gpr_operand_fetch
    import vx_gpr_operand_fetch_pkg::*;
#(
    parameter int unsigned NUM_WARPS = 4,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned DATAW     = 128,
    parameter int unsigned TAGW      = 8,
    parameter int unsigned ZERO_R0   = 1,
    localparam int unsigned WIDW     = $clog2(NUM_WARPS),
    localparam int unsigned RIDW     = $clog2(NUM_REGS),
    localparam int unsigned ADDRW    = WIDW + RIDW
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDW-1:0]  req_wid,
    input  logic [RIDW-1:0]  req_rs1,
    input  logic [RIDW-1:0]  req_rs2,
    input  logic [RIDW-1:0]  req_rs3,
    input  logic             req_use_rs3,
    input  logic [TAGW-1:0]  req_tag,

    input  logic             wb_valid,
    input  logic [WIDW-1:0]  wb_wid,
    input  logic [RIDW-1:0]  wb_rd,
    input  logic [DATAW-1:0] wb_data,

    output logic             ram_wren,
    output logic [ADDRW-1:0] ram_waddr,
    output logic [DATAW-1:0] ram_wdata,
    output logic [ADDRW-1:0] ram_raddr1,
    output logic [ADDRW-1:0] ram_raddr2,
    input  logic [DATAW-1:0] ram_rdata1,
    input  logic [DATAW-1:0] ram_rdata2,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDW-1:0]  rsp_wid,
    output logic [TAGW-1:0]  rsp_tag,
    output logic [DATAW-1:0] rsp_rs1_data,
    output logic [DATAW-1:0] rsp_rs2_data,
    output logic [DATAW-1:0] rsp_rs3_data
);

    fetch_state_t     state_q, state_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDW-1:0]  rsp_wid_q, rsp_wid_d;
    logic [TAGW-1:0]  rsp_tag_q, rsp_tag_d;
    logic [DATAW-1:0] rsp_rs1_q, rsp_rs1_d;
    logic [DATAW-1:0] rsp_rs2_q, rsp_rs2_d;
    logic [DATAW-1:0] rsp_rs3_q, rsp_rs3_d;

    // Staging for a three-operand request while rs3 is fetched.
    logic [WIDW-1:0]  stg_wid_q, stg_wid_d;
    logic [TAGW-1:0]  stg_tag_q, stg_tag_d;
    logic [DATAW-1:0] stg_rs1_q, stg_rs1_d;
    logic [DATAW-1:0] stg_rs2_q, stg_rs2_d;
    logic [RIDW-1:0]  stg_rs3_q, stg_rs3_d;

    logic             slot_free;
    logic             accept;
    logic [DATAW-1:0] fwd1, fwd2;

    // ---------------- Write path ----------------
    always_comb begin
        ram_wren  = wb_valid && !reset && !((ZERO_R0 != 0) && (wb_rd == '0));
        ram_waddr = ADDRW'(gpr_addr(32'(wb_wid), 32'(wb_rd), RIDW));
        ram_wdata = wb_data;
    end

    // ---------------- Read addressing and request handshake ----------------
    assign slot_free = !rsp_valid_q || rsp_ready;

    always_comb begin
        req_ready  = 1'b0;
        ram_raddr1 = '0;
        ram_raddr2 = '0;
        case (state_q)
            FETCH_IDLE: begin
                req_ready  = slot_free;
                ram_raddr1 = ADDRW'(gpr_addr(32'(req_wid), 32'(req_rs1), RIDW));
                ram_raddr2 = ADDRW'(gpr_addr(32'(req_wid), 32'(req_rs2), RIDW));
            end
            FETCH_READ3: begin
                // Re-read rs3 every cycle so a stalled response still sees later writebacks.
                ram_raddr1 = ADDRW'(gpr_addr(32'(stg_wid_q), 32'(stg_rs3_q), RIDW));
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    assign accept = req_valid && req_ready;

    vx_gpr_bypass #(
        .ADDRW   (ADDRW),
        .DATAW   (DATAW),
        .RIDW    (RIDW),
        .ZERO_R0 (ZERO_R0)
    ) u_bypass1 (
        .raddr    (ram_raddr1),
        .rdata    (ram_rdata1),
        .wren     (ram_wren),
        .waddr    (ram_waddr),
        .wdata    (ram_wdata),
        .fwd_data (fwd1)
    );

    vx_gpr_bypass #(
        .ADDRW   (ADDRW),
        .DATAW   (DATAW),
        .RIDW    (RIDW),
        .ZERO_R0 (ZERO_R0)
    ) u_bypass2 (
        .raddr    (ram_raddr2),
        .rdata    (ram_rdata2),
        .wren     (ram_wren),
        .waddr    (ram_waddr),
        .wdata    (ram_wdata),
        .fwd_data (fwd2)
    );

    // ---------------- Next state ----------------
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_wid_d   = rsp_wid_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_rs1_d   = rsp_rs1_q;
        rsp_rs2_d   = rsp_rs2_q;
        rsp_rs3_d   = rsp_rs3_q;
        stg_wid_d   = stg_wid_q;
        stg_tag_d   = stg_tag_q;
        stg_rs1_d   = stg_rs1_q;
        stg_rs2_d   = stg_rs2_q;
        stg_rs3_d   = stg_rs3_q;

        // Handshake drains the slot; a load below in the same cycle overrides this.
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            FETCH_IDLE: begin
                if (accept) begin
                    if (!req_use_rs3) begin
                        rsp_valid_d = 1'b1;
                        rsp_wid_d   = req_wid;
                        rsp_tag_d   = req_tag;
                        rsp_rs1_d   = fwd1;
                        rsp_rs2_d   = fwd2;
                        rsp_rs3_d   = '0;
                    end else begin
                        stg_wid_d = req_wid;
                        stg_tag_d = req_tag;
                        stg_rs1_d = fwd1;
                        stg_rs2_d = fwd2;
                        stg_rs3_d = req_rs3;
                        state_d   = FETCH_READ3;
                    end
                end
            end
            FETCH_READ3: begin
                if (slot_free) begin
                    rsp_valid_d = 1'b1;
                    rsp_wid_d   = stg_wid_q;
                    rsp_tag_d   = stg_tag_q;
                    rsp_rs1_d   = stg_rs1_q;
                    rsp_rs2_d   = stg_rs2_q;
                    rsp_rs3_d   = fwd1;
                    state_d     = FETCH_IDLE;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    // ---------------- State ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_wid_q   <= '0;
            rsp_tag_q   <= '0;
            rsp_rs1_q   <= '0;
            rsp_rs2_q   <= '0;
            rsp_rs3_q   <= '0;
            stg_wid_q   <= '0;
            stg_tag_q   <= '0;
            stg_rs1_q   <= '0;
            stg_rs2_q   <= '0;
            stg_rs3_q   <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wid_q   <= rsp_wid_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_rs1_q   <= rsp_rs1_d;
            rsp_rs2_q   <= rsp_rs2_d;
            rsp_rs3_q   <= rsp_rs3_d;
            stg_wid_q   <= stg_wid_d;
            stg_tag_q   <= stg_tag_d;
            stg_rs1_q   <= stg_rs1_d;
            stg_rs2_q   <= stg_rs2_d;
            stg_rs3_q   <= stg_rs3_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_wid      = rsp_wid_q;
    assign rsp_tag      = rsp_tag_q;
    assign rsp_rs1_data = rsp_rs1_q;
    assign rsp_rs2_data = rsp_rs2_q;
    assign rsp_rs3_data = rsp_rs3_q;

endmodule

// File: tb/tb_vx_gpr_operand_fetch.sv
// Bench for vx_gpr_operand_fetch: directed scenarios followed by randomized traffic, all checked
// against a register-file model that predicts each response's operands at acceptance time.
module tb_vx_gpr_operand_fetch;

    localparam int unsigned NW    = 4;
    localparam int unsigned NR    = 32;
    localparam int unsigned DW    = 128;
    localparam int unsigned TW    = 8;
    localparam int unsigned AW    = 7;
    localparam logic [DW-1:0] PRELOAD = {16{8'hA5}};

    logic          clk;
    logic          reset;
    logic          req_valid, req_ready;
    logic [1:0]    req_wid;
    logic [4:0]    req_rs1, req_rs2, req_rs3;
    logic          req_use_rs3;
    logic [TW-1:0] req_tag;
    logic          wb_valid;
    logic [1:0]    wb_wid;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic          ram_wren;
    logic [AW-1:0] ram_waddr, ram_raddr1, ram_raddr2;
    logic [DW-1:0] ram_wdata, ram_rdata1, ram_rdata2;
    logic          rsp_valid, rsp_ready;
    logic [1:0]    rsp_wid;
    logic [TW-1:0] rsp_tag;
    logic [DW-1:0] rsp_rs1_data, rsp_rs2_data, rsp_rs3_data;

    vx_gpr_operand_fetch #(
        .NUM_WARPS (NW),
        .NUM_REGS  (NR),
        .DATAW     (DW),
        .TAGW      (TW),
        .ZERO_R0   (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wid      (req_wid),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_rs3      (req_rs3),
        .req_use_rs3  (req_use_rs3),
        .req_tag      (req_tag),
        .wb_valid     (wb_valid),
        .wb_wid       (wb_wid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .ram_wren     (ram_wren),
        .ram_waddr    (ram_waddr),
        .ram_wdata    (ram_wdata),
        .ram_raddr1   (ram_raddr1),
        .ram_raddr2   (ram_raddr2),
        .ram_rdata1   (ram_rdata1),
        .ram_rdata2   (ram_rdata2),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_wid      (rsp_wid),
        .rsp_tag      (rsp_tag),
        .rsp_rs1_data (rsp_rs1_data),
        .rsp_rs2_data (rsp_rs2_data),
        .rsp_rs3_data (rsp_rs3_data)
    );

    // GPR RAM owned by the environment: synchronous write, asynchronous read.
    logic          preload;
    logic [DW-1:0] ram [128];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) ram[i] <= PRELOAD;
        end else if (ram_wren) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    assign ram_rdata1 = ram[ram_raddr1];
    assign ram_rdata2 = ram[ram_raddr2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- Reference model ----------------
    typedef struct {
        logic [1:0]    wid;
        logic [TW-1:0] tag;
        logic [4:0]    rs1, rs2, rs3;
        logic          use3;
        logic [DW-1:0] d1, d2, d3;
    } exp_t;

    logic [DW-1:0] shadow [NW][NR];
    exp_t          exp_q [$];
    int            n_checks;
    int            n_fail;
    logic          last_acc;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] reg_val(input logic [1:0] wid, input logic [4:0] rid);
        if (rid == 5'd0) return '0;
        return shadow[wid][rid];
    endfunction

    // Writeback to a source of a request still awaiting its response would break the
    // scoreboard guarantee, so random stimulus avoids it.
    function automatic bit wb_conflict(input logic [1:0] wid, input logic [4:0] rd);
        foreach (exp_q[i]) begin
            if (exp_q[i].wid == wid &&
                (rd == exp_q[i].rs1 || rd == exp_q[i].rs2 || (exp_q[i].use3 && rd == exp_q[i].rs3)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock cycle with the inputs already driven: check outputs, update the model, advance.
    task automatic tick();
        exp_t e;
        #1;
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rsp_spurious", DW'(rsp_valid), DW'(0));
            end else begin
                check("rsp_wid", DW'(rsp_wid), DW'(exp_q[0].wid));
                check("rsp_tag", DW'(rsp_tag), DW'(exp_q[0].tag));
                check("rsp_rs1", rsp_rs1_data, exp_q[0].d1);
                check("rsp_rs2", rsp_rs2_data, exp_q[0].d2);
                check("rsp_rs3", rsp_rs3_data, exp_q[0].d3);
            end
            if (!rsp_ready) check("hold_req_ready", DW'(req_ready), DW'(0));
        end
        if (rsp_valid === 1'b1 && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());

        if (wb_valid && !reset && wb_rd != 5'd0) shadow[wb_wid][wb_rd] = wb_data;

        last_acc = 1'b0;
        if (reset) begin
            exp_q.delete();
        end else if (req_valid && req_ready === 1'b1) begin
            last_acc = 1'b1;
            e.wid  = req_wid;
            e.tag  = req_tag;
            e.rs1  = req_rs1;
            e.rs2  = req_rs2;
            e.rs3  = req_rs3;
            e.use3 = req_use_rs3;
            e.d1   = reg_val(req_wid, req_rs1);
            e.d2   = reg_val(req_wid, req_rs2);
            e.d3   = req_use_rs3 ? reg_val(req_wid, req_rs3) : '0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input logic v, input logic [1:0] wid, input logic [4:0] r1,
                           input logic [4:0] r2, input logic [4:0] r3, input logic u3,
                           input logic [TW-1:0] tag);
        req_valid   = v;
        req_wid     = wid;
        req_rs1     = r1;
        req_rs2     = r2;
        req_rs3     = r3;
        req_use_rs3 = u3;
        req_tag     = tag;
    endtask

    task automatic set_wb(input logic v, input logic [1:0] wid, input logic [4:0] rd,
                          input logic [DW-1:0] d);
        wb_valid = v;
        wb_wid   = wid;
        wb_rd    = rd;
        wb_data  = d;
    endtask

    int stall_cnt;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_acc = 1'b0;
        for (int w = 0; w < int'(NW); w++)
            for (int r = 0; r < int'(NR); r++) shadow[w][r] = PRELOAD;

        // ---- Reset with writeback asserted ----
        preload   = 1'b1;
        reset     = 1'b1;
        rsp_ready = 1'b1;
        set_req(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 8'h00);
        set_wb(1'b1, 2'd1, 5'd3, 128'hDEAD);
        @(negedge clk);
        tick();
        preload = 1'b0;
        tick();
        tick();
        #1;
        check("reset_rsp_valid", DW'(rsp_valid), DW'(0));
        check("reset_ram_wren", DW'(ram_wren), DW'(0));
        check("reset_rsp_rs1", rsp_rs1_data, DW'(0));
        check("reset_rsp_tag", DW'(rsp_tag), DW'(0));
        reset = 1'b0;
        set_wb(1'b0, 2'd0, 5'd0, '0);

        // ---- Two-operand request ----
        set_wb(1'b1, 2'd1, 5'd5, 128'h11);
        #1;
        check("wb_wren", DW'(ram_wren), DW'(1));
        check("wb_waddr", DW'(ram_waddr), DW'(1 * 32 + 5));
        tick();
        set_wb(1'b1, 2'd1, 5'd6, 128'h22);
        tick();
        set_wb(1'b0, 2'd0, 5'd0, '0);
        set_req(1'b1, 2'd1, 5'd5, 5'd6, 5'd0, 1'b0, 8'h3C);
        #1;
        check("op2_req_ready", DW'(req_ready), DW'(1));
        tick();
        req_valid = 1'b0;
        check("op2_rsp_valid", DW'(rsp_valid), DW'(1));
        check("op2_rs1", rsp_rs1_data, 128'h11);
        check("op2_rs2", rsp_rs2_data, 128'h22);
        check("op2_rs3", rsp_rs3_data, 128'h0);
        check("op2_tag", DW'(rsp_tag), DW'(8'h3C));

        // ---- Three-operand request ----
        set_wb(1'b1, 2'd1, 5'd7, 128'h33);
        tick();
        set_wb(1'b0, 2'd0, 5'd0, '0);
        set_req(1'b1, 2'd1, 5'd5, 5'd6, 5'd7, 1'b1, 8'h5A);
        tick();
        req_valid = 1'b0;
        check("op3_req_ready_busy", DW'(req_ready), DW'(0));
        check("op3_rsp_valid_p1", DW'(rsp_valid), DW'(0));
        tick();
        check("op3_rsp_valid_p2", DW'(rsp_valid), DW'(1));
        check("op3_rs3", rsp_rs3_data, 128'h33);
        check("op3_rs1", rsp_rs1_data, 128'h11);

        // ---- Same-cycle bypass and r0 ----
        set_wb(1'b1, 2'd0, 5'd9, 128'hBEEF);
        set_req(1'b1, 2'd0, 5'd9, 5'd0, 5'd0, 1'b0, 8'h11);
        tick();
        set_wb(1'b0, 2'd0, 5'd0, '0);
        req_valid = 1'b0;
        check("byp_rs1", rsp_rs1_data, 128'hBEEF);
        set_wb(1'b1, 2'd0, 5'd0, 128'h1234);
        #1;
        check("r0_wren", DW'(ram_wren), DW'(0));
        tick();
        set_wb(1'b0, 2'd0, 5'd0, '0);
        set_req(1'b1, 2'd0, 5'd0, 5'd9, 5'd0, 1'b0, 8'h22);
        tick();
        req_valid = 1'b0;
        check("r0_rs1", rsp_rs1_data, 128'h0);
        check("r0_rs2", rsp_rs2_data, 128'hBEEF);
        tick();

        // ---- Back-pressure under back-to-back requests ----
        rsp_ready = 1'b0;
        set_req(1'b1, 2'd2, 5'd1, 5'd2, 5'd0, 1'b0, 8'h40);
        tick();
        set_req(1'b1, 2'd2, 5'd3, 5'd4, 5'd0, 1'b0, 8'h41);
        for (int i = 0; i < 4; i++) tick();
        check("bp_rsp_tag", DW'(rsp_tag), DW'(8'h40));
        rsp_ready = 1'b1;
        for (int i = 0; i < 5 && req_valid; i++) begin
            tick();
            if (last_acc) req_valid = 1'b0;
        end
        for (int i = 0; i < 4; i++) tick();
        check("bp_drained", DW'(exp_q.size()), DW'(0));

        // ---- Reset while in READ3 ----
        set_req(1'b1, 2'd3, 5'd1, 5'd2, 5'd3, 1'b1, 8'h77);
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst3_no_rsp", DW'(rsp_valid), DW'(0));
            tick();
        end
        set_req(1'b1, 2'd3, 5'd1, 5'd2, 5'd0, 1'b0, 8'h78);
        tick();
        req_valid = 1'b0;
        check("post_rst_valid", DW'(rsp_valid), DW'(1));
        check("post_rst_tag", DW'(rsp_tag), DW'(8'h78));
        tick();

        // ---- Randomized traffic ----
        stall_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            if (stall_cnt > 0) begin
                rsp_ready = 1'b0;
                stall_cnt--;
            end else if ($urandom_range(0, 19) == 0) begin
                rsp_ready = 1'b0;
                stall_cnt = 3;
            end else begin
                rsp_ready = ($urandom_range(0, 4) != 0);
            end

            if (!req_valid || last_acc) begin
                set_req($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                        5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                        5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 255)));
            end

            set_wb($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                   5'($urandom_range(0, 31)), {$urandom, $urandom, $urandom, $urandom});
            if (wb_conflict(wb_wid, wb_rd)) wb_valid = 1'b0;
            tick();
        end

        req_valid = 1'b0;
        wb_valid  = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        check("final_drained", DW'(exp_q.size()), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
